// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

   typedef enum logic {HZ_RUN, HZ_MDU_WAIT} hz_state_e;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   // True when a DE source operand is actually read and names the given rd.
   function automatic logic src_match(input reg_idx_t rs,
                                      input logic     used,
                                      input reg_idx_t rd);
      return used && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: counts cycles with inc high, holds at all-ones.
module hazard_perf_cnt
   import hazard_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc until all-ones, then hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: load-use stall,
// taken-branch flush and multi-cycle MDU freeze. Drives stage-register
// enables/flushes and the PC enable.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating perf counters
// (stall_cnt, flush_cnt, mdu_cnt); control behaviour is identical either way.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  reg_idx_t          rs1_de,
   input  reg_idx_t          rs2_de,
   input  logic              rs1_used_de,
   input  logic              rs2_used_de,
   input  reg_idx_t          rd_ex,
   input  logic              RUWr_ex,
   input  logic              DMRd_ex,
   input  logic              br_taken_ex,
   input  logic              mdu_start_ex,
   output logic              pc_en,
   output logic              if_de_en,
   output logic              if_de_flush,
   output logic              de_ex_en,
   output logic              de_ex_flush,
   output logic              ex_me_bubble,
   output logic              mdu_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt,
   output logic [PERF_W-1:0] mdu_cnt
`endif
);

   localparam int CNT_W = $clog2(MDU_LAT) + 1;
   // A single-cycle MDU op needs no freeze, so the FSM never leaves RUN.
   localparam bit MDU_FREEZE_EN = (MDU_LAT > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = MDU_FREEZE_EN ? CNT_W'(MDU_LAT - 2) : '0;

   hz_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             load_use;
   logic             stall_ev, flush_ev, freeze_ev;

   assign load_use = DMRd_ex && RUWr_ex && (rd_ex != REG_ZERO) &&
                     (src_match(rs1_de, rs1_used_de, rd_ex) ||
                      src_match(rs2_de, rs2_used_de, rd_ex));

   // State and wait-counter registers.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; the combinational block below uses blocking (=).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HZ_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and control outputs; priority in RUN is branch > MDU > load-use.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_en        = 1'b1;
      if_de_en     = 1'b1;
      if_de_flush  = 1'b0;
      de_ex_en     = 1'b1;
      de_ex_flush  = 1'b0;
      ex_me_bubble = 1'b0;
      mdu_busy     = 1'b0;
      stall_ev     = 1'b0;
      flush_ev     = 1'b0;
      freeze_ev    = 1'b0;
      // While reset is asserted the pipeline sees idle controls, even if
      // EX still presents an MDU op or a hazard.
      if (rst_n) begin
         unique case (state)
            HZ_RUN: begin
               if (br_taken_ex) begin
                  // DE and EX hold wrong-path instructions; squash both.
                  if_de_flush = 1'b1;
                  de_ex_flush = 1'b1;
                  flush_ev    = 1'b1;
               end else if (mdu_start_ex && MDU_FREEZE_EN) begin
                  pc_en        = 1'b0;
                  if_de_en     = 1'b0;
                  de_ex_en     = 1'b0;
                  ex_me_bubble = 1'b1;
                  freeze_ev    = 1'b1;
                  cnt_nxt      = CNT_LOAD;
                  state_nxt    = HZ_MDU_WAIT;
               end else if (load_use) begin
                  // One bubble; next cycle the load is in ME and forwards.
                  pc_en       = 1'b0;
                  if_de_en    = 1'b0;
                  de_ex_flush = 1'b1;
                  stall_ev    = 1'b1;
               end
            end
            HZ_MDU_WAIT: begin
               mdu_busy = 1'b1;
               if (cnt != '0) begin
                  pc_en        = 1'b0;
                  if_de_en     = 1'b0;
                  de_ex_en     = 1'b0;
                  ex_me_bubble = 1'b1;
                  freeze_ev    = 1'b1;
                  cnt_nxt      = cnt - CNT_W'(1);
               end else begin
                  // The MDU op leaves EX on this edge.
                  state_nxt = HZ_RUN;
               end
            end
            default: begin
               state_nxt = HZ_RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_ev),
      .count (stall_cnt)
   );

   hazard_perf_cnt #(.W(PERF_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_ev),
      .count (flush_cnt)
   );

   hazard_perf_cnt #(.W(PERF_W)) u_mdu_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (freeze_ev),
      .count (mdu_cnt)
   );
`else
   localparam int perf_w_unused = PERF_W;
   logic unused_events;
   assign unused_events = stall_ev ^ flush_ev ^ freeze_ev;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MDU_LAT=4, PERF_W=2 so the perf
// counters reach saturation quickly when HAZARD_PERF_CNT_EN is defined).
module tb_hazard_ctrl;
   import hazard_pkg::*;

   // {pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_flush, ex_me_bubble, mdu_busy}
   localparam logic [6:0] O_IDLE  = 7'b1101000;
   localparam logic [6:0] O_STALL = 7'b0001100;
   localparam logic [6:0] O_FLUSH = 7'b1111100;
   localparam logic [6:0] O_FRZ   = 7'b0000010;
   localparam logic [6:0] O_FRZ_W = 7'b0000011;
   localparam logic [6:0] O_REL   = 7'b1101001;

   logic     clk = 1'b0;
   logic     rst_n;
   reg_idx_t rs1_de, rs2_de, rd_ex;
   logic     rs1_used_de, rs2_used_de, RUWr_ex, DMRd_ex, br_taken_ex, mdu_start_ex;
   logic     pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_flush, ex_me_bubble, mdu_busy;
   logic [6:0] outs;
`ifdef HAZARD_PERF_CNT_EN
   logic [1:0] stall_cnt, flush_cnt, mdu_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   assign outs = {pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_flush, ex_me_bubble, mdu_busy};

   always #5 clk = ~clk;

   hazard_ctrl #(.MDU_LAT(4), .PERF_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rs1_de       (rs1_de),
      .rs2_de       (rs2_de),
      .rs1_used_de  (rs1_used_de),
      .rs2_used_de  (rs2_used_de),
      .rd_ex        (rd_ex),
      .RUWr_ex      (RUWr_ex),
      .DMRd_ex      (DMRd_ex),
      .br_taken_ex  (br_taken_ex),
      .mdu_start_ex (mdu_start_ex),
      .pc_en        (pc_en),
      .if_de_en     (if_de_en),
      .if_de_flush  (if_de_flush),
      .de_ex_en     (de_ex_en),
      .de_ex_flush  (de_ex_flush),
      .ex_me_bubble (ex_me_bubble),
      .mdu_busy     (mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .mdu_cnt      (mdu_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic br, input logic mdu);
      rs1_de       = r1;
      rs1_used_de  = u1;
      rs2_de       = r2;
      rs2_used_de  = u2;
      rd_ex        = rd;
      RUWr_ex      = wr;
      DMRd_ex      = ld;
      br_taken_ex  = br;
      mdu_start_ex = mdu;
   endtask

   // One clock cycle: apply inputs just after the edge, sample mid-cycle.
   task automatic cyc(input string tag,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic ld,
                      input logic br, input logic mdu,
                      input logic [6:0] exp);
      @(posedge clk);
      #1;
      drive(r1, u1, r2, u2, rd, wr, ld, br, mdu);
      #3;
      check(tag, 32'(outs), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      check("reset_outs", 32'(outs), 32'(O_IDLE));
`ifdef HAZARD_PERF_CNT_EN
      check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      check("reset_mdu_cnt",   32'(mdu_cnt),   32'd0);
`endif
      #5 rst_n = 1'b1;

      // Load-use detection
      cyc("lu_rs1",        5, 1, 0, 0, 5, 1, 1, 0, 0, O_STALL);
      cyc("lu_done",       0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
      cyc("lu_rd_zero",    0, 1, 0, 0, 0, 1, 1, 0, 0, O_IDLE);
      cyc("lu_rs1_unused", 5, 0, 0, 0, 5, 1, 1, 0, 0, O_IDLE);
      cyc("lu_rs2",        3, 1, 5, 1, 5, 1, 1, 0, 0, O_STALL);
      cyc("lu_no_ruwr",    5, 1, 0, 0, 5, 0, 1, 0, 0, O_IDLE);
      cyc("lu_not_load",   5, 1, 0, 0, 5, 1, 0, 0, 0, O_IDLE);

      // Branch priority
      cyc("br_masks_lu",   5, 1, 0, 0, 5, 1, 1, 1, 0, O_FLUSH);
      cyc("br_over_mdu",   0, 0, 0, 0, 0, 0, 0, 1, 1, O_FLUSH);
      cyc("run_after_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);

      // MDU freeze, MDU_LAT=4: three frozen cycles then release
      cyc("mdu_f1",        0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
      cyc("mdu_f2_br_ign", 0, 0, 0, 0, 0, 0, 0, 1, 1, O_FRZ_W);
      cyc("mdu_f3",        0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ_W);
      cyc("mdu_rel_lu_ign",5, 1, 0, 0, 5, 1, 1, 0, 1, O_REL);
      cyc("lu_after_mdu",  5, 1, 0, 0, 5, 1, 1, 0, 0, O_STALL);
      cyc("lu_again",      7, 1, 0, 0, 7, 1, 1, 0, 0, O_STALL);
      cyc("idle_pre_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cnt_sat", 32'(stall_cnt), 32'd3);
      check("flush_cnt",     32'(flush_cnt), 32'd2);
      check("mdu_cnt",       32'(mdu_cnt),   32'd3);
`endif

      // Reset asserted during the second freeze cycle
      cyc("rst_f1",        0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
      cyc("rst_f2",        0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ_W);
`ifdef HAZARD_PERF_CNT_EN
      check("mdu_cnt_sat", 32'(mdu_cnt), 32'd3);
`endif
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_outs", 32'(outs), 32'(O_IDLE));
`ifdef HAZARD_PERF_CNT_EN
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      check("rst_mdu_cnt",   32'(mdu_cnt),   32'd0);
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b1;
      cyc("run_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
      cyc("lu_after_rst",  9, 1, 0, 0, 9, 1, 1, 0, 0, O_STALL);
      cyc("final_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cnt_after_rst", 32'(stall_cnt), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
